traffic_light_sequencer: RTL and testbench
==========================================

# traffic_light_sequencer

Moore state machine that sequences the main-street and side-street vehicle lights and the pedestrian walk phase of the traffic light controller. It advances on a one-cycle `Tick` enable from the prescaler, not on every clock. A side-street `Sensor` can extend side green once per cycle. A latched walk request `WR`, held by the walk register, inserts an all-red walk phase; the sequencer clears that request with a one-cycle `WR_Reset` pulse.

## Interface
- `T_BASE`, 6: main green and side green duration, in ticks (≥1).
- `T_EXT`, 3: one-time side green extension when `Sensor` is high, in ticks (≥1).
- `T_YEL`, 2: yellow duration for both streets, in ticks (≥1).
- `T_WALK`, 3: walk phase duration, in ticks (≥1).
- `CNT_W`, 4: tick counter width; every duration must be ≤ 2^CNT_W.
- `Clk`  in  1  system clock; all state changes happen on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Tick`  in  1  one-Clk-wide timing enable; durations count these pulses.
- `Sensor`  in  1  side-street vehicle present; synchronous to `Clk`.
- `WR`  in  1  walk request level from the walk register.
- `Main_RYG`  out  3  main street lights, {R,Y,G}, one-hot.
- `Side_RYG`  out  3  side street lights, {R,Y,G}, one-hot.
- `Walk`  out  1  pedestrian walk lamp.
- `WR_Reset`  out  1  one-cycle pulse that clears the walk register.
- `State`  out  3  current state encoding, for debug.

## Operation
- Encoded states:
  - MAIN_G = 0
  - MAIN_Y = 1
  - SIDE_G = 2
  - SIDE_Y = 3
  - WALK = 4
- Tick counter `cnt`:
  - Cleared on every state change.
  - Increments on `Tick` otherwise.
- A state expires on the Clk edge where `Tick`=1 and `cnt` = duration−1.
- Transitions (all taken only at expiry):
  - MAIN_G (T_BASE) → MAIN_Y.
  - MAIN_Y (T_YEL) → SIDE_G.
  - SIDE_G (T_BASE) → if `Sensor`=1 and `ext`=0: set `ext`, clear `cnt`, stay in SIDE_G for T_EXT more ticks. Otherwise → SIDE_Y.
  - SIDE_Y (T_YEL) → WALK if `WR`=1, else MAIN_G. `ext` is cleared on this exit.
  - WALK (T_WALK) → MAIN_G.
- `Sensor` is sampled only at SIDE_G expiry. `WR` is sampled only at SIDE_Y expiry. Requests arriving later wait for the next cycle through SIDE_Y.
- Output decode from the state register:
  - MAIN_G: Main=001, Side=100.
  - MAIN_Y: Main=010, Side=100.
  - SIDE_G: Main=100, Side=001.
  - SIDE_Y: Main=100, Side=010.
  - WALK: Main=100, Side=100, `Walk`=1.
- `WR_Reset`:
  - Registered.
  - High for exactly the first Clk cycle spent in WALK, low otherwise.
  - Never asserted outside WALK.
- Illegal state encodings (5–7) return to MAIN_G on the next Clk edge.

## Timing
- Reset values, asynchronous and immediate:
  - State = MAIN_G, `cnt`=0, `ext`=0.
  - `Main_RYG`=001, `Side_RYG`=100.
  - `Walk`=0, `WR_Reset`=0.
- Reset mid-operation:
  - Aborts any phase, including WALK.
  - A `WR_Reset` pulse in flight is dropped; `WR` stays latched in the walk register.
- Outputs change on the same Clk edge as the state, with no combinational path from inputs.
- `Tick`=0 freezes the state and `cnt`. `Sensor` and `WR` have no effect except at an expiry edge.
- Nominal period with no sensor and no walk is 2·T_BASE + 2·T_YEL ticks (16 with defaults).

## Configuration
- `WALK_PHASE_EN` defined: WALK state, `Walk` and `WR_Reset` logic are present, as described above.
- `WALK_PHASE_EN` undefined:
  - WALK state and the `T_WALK` logic are removed.
  - SIDE_Y always goes to MAIN_G.
  - `WR` is ignored.
  - `Walk` and `WR_Reset` are tied to 0.
  - Ports are unchanged.

## Test plan
- Basic cycle. Defaults, `Tick`=1 every cycle, `Sensor`=0, `WR`=0 → MAIN_G 6 cycles, MAIN_Y 2, SIDE_G 6, SIDE_Y 2; period 16; `Walk` and `WR_Reset` stay 0.
- Sensor extension. `Sensor` held at 1 → SIDE_G lasts exactly 9 cycles (not re-extended); following SIDE_G is also 9 cycles.
- Walk phase. `WR`=1 before SIDE_Y expiry → WALK for 3 cycles with Main=Side=100 and `Walk`=1; `WR_Reset` high for 1 cycle at WALK entry; then MAIN_G. With `WR` dropped, the next cycle has no WALK.
- Tick stall. `Tick` pulsed every 4th Clk → each state lasts 4× its duration in Clk cycles; no transition on non-Tick edges.
- Reset mid-operation. `Reset` asserted for 1 cycle mid SIDE_G and again mid WALK → outputs 001/100, `Walk`=0 immediately (before the next edge); MAIN_G lasts 6 ticks after release.
- Macro off. `WALK_PHASE_EN` undefined, `WR`=1 held → period 16; `Walk`=`WR_Reset`=0 throughout.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// Moore sequencer for main/side vehicle lights with an optional all-red pedestrian walk phase.
// Optional feature: define WALK_PHASE_EN to build the WALK state, Walk lamp and WR_Reset pulse.
module traffic_light_sequencer #(
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2,
  parameter int unsigned T_WALK = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Sensor,
  input  logic       WR,
  output logic [2:0] Main_RYG,
  output logic [2:0] Side_RYG,
  output logic       Walk,
  output logic       WR_Reset,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    SIDE_G = 3'd2,
    SIDE_Y = 3'd3
`ifdef WALK_PHASE_EN
    ,
    WALK   = 3'd4
`endif
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Counter terminal values: a state lasts N ticks, so it expires at cnt == N-1.
  localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(T_BASE - 1);
  localparam logic [CNT_W-1:0] LAST_EXT  = CNT_W'(T_EXT - 1);
  localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL - 1);
`ifdef WALK_PHASE_EN
  localparam logic [CNT_W-1:0] LAST_WALK = CNT_W'(T_WALK - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_q, ext_d;
  logic [CNT_W-1:0] last_cnt;
  logic             expire;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= MAIN_G;
      cnt_q   <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
    end
  end

  always_comb begin
    last_cnt = LAST_BASE;
    case (state_q)
      MAIN_Y, SIDE_Y: last_cnt = LAST_YEL;
      SIDE_G:         last_cnt = ext_q ? LAST_EXT : LAST_BASE;
`ifdef WALK_PHASE_EN
      WALK:           last_cnt = LAST_WALK;
`endif
      default:        last_cnt = LAST_BASE;
    endcase
  end

  assign expire = Tick && (cnt_q == last_cnt);

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    cnt_d   = Tick ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      MAIN_G: if (expire) state_d = MAIN_Y;
      MAIN_Y: if (expire) state_d = SIDE_G;
      SIDE_G: begin
        if (expire) begin
          // Extension restarts the count in place without leaving SIDE_G.
          if (Sensor && !ext_q) begin
            ext_d = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = SIDE_Y;
          end
        end
      end
      SIDE_Y: begin
        if (expire) begin
          ext_d = 1'b0;
`ifdef WALK_PHASE_EN
          state_d = WR ? WALK : MAIN_G;
`else
          state_d = MAIN_G;
`endif
        end
      end
`ifdef WALK_PHASE_EN
      WALK: if (expire) state_d = MAIN_G;
`endif
      default: state_d = MAIN_G;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

`ifdef WALK_PHASE_EN
  logic wr_reset_q, wr_reset_d;

  // Pulse is registered alongside the state so it aligns with the first WALK cycle.
  always_comb begin
    wr_reset_d = (state_d == WALK) && (state_q != WALK);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) wr_reset_q <= 1'b0;
    else       wr_reset_q <= wr_reset_d;
  end

  assign WR_Reset = wr_reset_q;
`else
  logic unused_walk;
  assign unused_walk = ^{WR, 32'(T_WALK)};
  assign WR_Reset    = 1'b0;
`endif

  always_comb begin
    Main_RYG = LAMP_G;
    Side_RYG = LAMP_R;
    Walk     = 1'b0;
    case (state_q)
      MAIN_G: begin Main_RYG = LAMP_G; Side_RYG = LAMP_R; end
      MAIN_Y: begin Main_RYG = LAMP_Y; Side_RYG = LAMP_R; end
      SIDE_G: begin Main_RYG = LAMP_R; Side_RYG = LAMP_G; end
      SIDE_Y: begin Main_RYG = LAMP_R; Side_RYG = LAMP_Y; end
`ifdef WALK_PHASE_EN
      WALK: begin
        Main_RYG = LAMP_R;
        Side_RYG = LAMP_R;
        Walk     = 1'b1;
      end
`endif
      default: begin Main_RYG = LAMP_G; Side_RYG = LAMP_R; end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: phase lengths, sensor extension, walk, tick stall, reset.
module tb_traffic_light_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] S_MG = 3'd0;
  localparam logic [2:0] S_MY = 3'd1;
  localparam logic [2:0] S_SG = 3'd2;
  localparam logic [2:0] S_SY = 3'd3;
  localparam logic [2:0] S_WK = 3'd4;

  logic       Clk, Reset, Tick, Sensor, WR;
  logic [2:0] Main_RYG, Side_RYG, State;
  logic       Walk, WR_Reset;

  int tests = 0;
  int fails = 0;
  int walk_cycles = 0;
  int wrr_cycles = 0;
  int bad_cycles = 0;
  bit div4 = 1'b0;

  traffic_light_sequencer #(
    .T_BASE(6), .T_EXT(3), .T_YEL(2), .T_WALK(3), .CNT_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Sensor(Sensor), .WR(WR),
    .Main_RYG(Main_RYG), .Side_RYG(Side_RYG), .Walk(Walk),
    .WR_Reset(WR_Reset), .State(State)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    int ph;
    ph = 0;
    Tick = 1'b1;
    forever begin
      @(negedge Clk);
      if (div4) begin
        Tick = (ph == 0);
        ph = (ph + 1) % 4;
      end else begin
        Tick = 1'b1;
        ph = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (Walk) walk_cycles++;
      if (WR_Reset) wrr_cycles++;
      if ((Walk || WR_Reset) && State != S_WK) bad_cycles++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Called at the first negedge of a phase; returns at the first negedge of the next phase.
  task automatic check_phase(input string tag, input logic [2:0] st, input int len,
                             input logic [2:0] m, input logic [2:0] s);
    int n;
    n = 0;
    check({tag, " state"}, State, st);
    check({tag, " main"}, Main_RYG, m);
    check({tag, " side"}, Side_RYG, s);
    while (State == st && n < 400) begin
      n++;
      @(negedge Clk);
    end
    check({tag, " len"}, n, len);
  endtask

  task automatic wait_change(input string tag, input logic [2:0] st);
    int n;
    n = 0;
    while (State == st && n < 400) begin
      n++;
      @(negedge Clk);
    end
    check({tag, " timeout"}, (n < 400), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"}, State, S_MG);
    check({tag, " main"}, Main_RYG, G);
    check({tag, " side"}, Side_RYG, R);
    check({tag, " walk"}, Walk, 0);
    check({tag, " wr_reset"}, WR_Reset, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Sensor = 1'b0;
    WR = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // Basic cycle, period 16
    check_phase("b_mg", S_MG, 6, G, R);
    check_phase("b_my", S_MY, 2, Y, R);
    check_phase("b_sg", S_SG, 6, R, G);
    check_phase("b_sy", S_SY, 2, R, Y);
    check_phase("b_mg2", S_MG, 6, G, R);
    check_phase("b_my2", S_MY, 2, Y, R);

    // Sensor held: extended once per pass through SIDE_G
    Sensor = 1'b1;
    check_phase("s_sg", S_SG, 9, R, G);
    check_phase("s_sy", S_SY, 2, R, Y);
    check_phase("s_mg", S_MG, 6, G, R);
    check_phase("s_my", S_MY, 2, Y, R);
    check_phase("s_sg2", S_SG, 9, R, G);
    check_phase("s_sy2", S_SY, 2, R, Y);
    Sensor = 1'b0;

    // Walk request latched before SIDE_Y expiry
    WR = 1'b1;
    check_phase("w_mg", S_MG, 6, G, R);
    check_phase("w_my", S_MY, 2, Y, R);
    check_phase("w_sg", S_SG, 6, R, G);
    check_phase("w_sy", S_SY, 2, R, Y);
`ifdef WALK_PHASE_EN
    check("w_entry walk", Walk, 1);
    check("w_entry wr_reset", WR_Reset, 1);
    WR = 1'b0;
    check_phase("w_walk", S_WK, 3, R, R);
`else
    WR = 1'b1;
`endif
    check_phase("n_mg", S_MG, 6, G, R);
    check_phase("n_my", S_MY, 2, Y, R);
    check_phase("n_sg", S_SG, 6, R, G);
    check_phase("n_sy", S_SY, 2, R, Y);
    WR = 1'b0;

    // Tick every 4th clock
    check("t_entry state", State, S_MG);
    div4 = 1'b1;
    wait_change("t_mg", S_MG);
    check_phase("t_my", S_MY, 8, Y, R);
    check_phase("t_sg", S_SG, 24, R, G);
    check_phase("t_sy", S_SY, 8, R, Y);
    check_phase("t_mg", S_MG, 24, G, R);
    div4 = 1'b0;
    wait_change("t_my2", S_MY);

    // Reset mid SIDE_G
    check("r_entry state", State, S_SG);
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("r_sg");
    @(negedge Clk);
    Reset = 1'b0;
    check_phase("r_mg", S_MG, 6, G, R);
    check_phase("r_my", S_MY, 2, Y, R);

`ifdef WALK_PHASE_EN
    // Reset on the first WALK cycle drops the WR_Reset pulse
    WR = 1'b1;
    check_phase("rw_sg", S_SG, 6, R, G);
    check_phase("rw_sy", S_SY, 2, R, Y);
    check("rw_entry state", State, S_WK);
    check("rw_entry wr_reset", WR_Reset, 1);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("r_walk");
    @(negedge Clk);
    Reset = 1'b0;
    WR = 1'b0;
    check_phase("rw_mg", S_MG, 6, G, R);
    check("walk cycles", walk_cycles, 4);
    check("wr_reset cycles", wrr_cycles, 2);
`else
    check_phase("r_sg2", S_SG, 6, R, G);
    check("walk cycles", walk_cycles, 0);
    check("wr_reset cycles", wrr_cycles, 0);
`endif
    check("walk outside WALK", bad_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
